bram_port_arbiter: RTL and testbench

//  Shares port A of one dual-port BRAM (HIGH_PERFORMANCE, 3-cycle read) between two requesters.
//  - Optionally zero-fills the BRAM after reset.
//  - Round-robin arbitration over a valid/ready request channel.
//  - Returns each read on the issuing requester's response port, in order, at fixed latency.
//  - Sits between the sample/waveform DMA engines and the shared buffer RAM.

---
 rtl/bram_port_arbiter_if.sv | 23 ++
 rtl/bram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - one requester's request/response channel into the BRAM port arbiter
interface bram_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 18
);
  logic          valid;
  logic          ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin sharing of BRAM port A between two requesters, with optional zero-fill
module bram_port_arbiter #(
  parameter int DATA_WIDTH     = 18,
  parameter int BRAM_DEPTH     = 1024,
  parameter int READ_LATENCY   = 3,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(BRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  bram_port_arbiter_if.slave    r0,
  bram_port_arbiter_if.slave    r1,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [AW-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_regce,
  output logic                  bram_rst,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(BRAM_DEPTH - 1);
  localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

  state_t                  state_q, state_d;
  logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
  logic                    prio_q, prio_d;
  logic                    iss_en_q, iss_en_d;
  logic                    iss_we_q, iss_we_d;
  logic [AW-1:0]           iss_addr_q, iss_addr_d;
  logic [DATA_WIDTH-1:0]   iss_din_q, iss_din_d;
  tag_t                    tag_q [READ_LATENCY+1];
  tag_t                    tag_d [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0]   rsp_data0_q, rsp_data0_d;
  logic [DATA_WIDTH-1:0]   rsp_data1_q, rsp_data1_d;

  logic in_arb;
  logic grant0;
  logic grant1;
  logic sel_we;
  logic rsp_valid0;
  logic rsp_valid1;

  // prio_q names the requester that wins when both are valid
  always_comb begin
    in_arb = (state_q == ST_ARB);
    grant0 = in_arb & r0.valid & (~r1.valid | ~prio_q);
    grant1 = in_arb & r1.valid & (~r0.valid |  prio_q);
    sel_we = grant1 ? r1.we : r0.we;
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    prio_d     = prio_q;
    iss_en_d   = 1'b0;
    iss_we_d   = 1'b0;
    iss_addr_d = iss_addr_q;
    iss_din_d  = iss_din_q;

    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (grant0) begin
      iss_en_d   = 1'b1;
      iss_we_d   = r0.we;
      iss_addr_d = r0.addr;
      iss_din_d  = r0.wdata;
      prio_d     = 1'b1;
    end else if (grant1) begin
      iss_en_d   = 1'b1;
      iss_we_d   = r1.we;
      iss_addr_d = r1.addr;
      iss_din_d  = r1.wdata;
      prio_d     = 1'b0;
    end
  end

  // Writes occupy a slot but carry no tag, so only reads come back
  always_comb begin
    tag_d[0] = '{valid: (grant0 | grant1) & ~sel_we, id: grant1};
    for (int i = 1; i <= READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rsp_valid0  = tag_q[READ_LATENCY].valid & ~tag_q[READ_LATENCY].id;
    rsp_valid1  = tag_q[READ_LATENCY].valid &  tag_q[READ_LATENCY].id;
    rsp_data0_d = rsp_valid0 ? bram_dout : rsp_data0_q;
    rsp_data1_d = rsp_valid1 ? bram_dout : rsp_data1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      prio_q      <= 1'b0;
      iss_en_q    <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_din_q   <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_q[i] <= '{valid: 1'b0, id: 1'b0};
      end
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      prio_q      <= prio_d;
      iss_en_q    <= iss_en_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_din_q   <= iss_din_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Fill drives the port straight from the counter so address 0 lands in the first cycle after reset
  assign init_done    = in_arb & ~rst;
  assign bram_en      = ~rst & (in_arb ? iss_en_q : 1'b1);
  assign bram_we      = ~rst & (in_arb ? iss_we_q : 1'b1);
  assign bram_addr    = in_arb ? iss_addr_q : clr_cnt_q;
  assign bram_din     = in_arb ? iss_din_q : '0;
  assign bram_regce   = 1'b1;
  assign bram_rst     = rst;

  assign r0.ready     = grant0 & ~rst;
  assign r1.ready     = grant1 & ~rst;
  assign r0.rsp_valid = rsp_valid0;
  assign r1.rsp_valid = rsp_valid1;
  assign r0.rsp_data  = rsp_data0_d;
  assign r1.rsp_data  = rsp_data1_d;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter with a 3-cycle read-first BRAM model
module tb_bram_port_arbiter;
  localparam int DW    = 18;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NRAND = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) r0_if ();
  bram_port_arbiter_if #(.AW(AW), .DW(DW)) r1_if ();
  bram_port_arbiter_if #(.AW(AW), .DW(DW)) q0_if ();
  bram_port_arbiter_if #(.AW(AW), .DW(DW)) q1_if ();

  logic          init_done, bram_en, bram_we, bram_regce, bram_rst;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;
  logic          init2, en2, we2, regce2, brst2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] din2, dout2;
  assign dout2 = '0;

  bram_port_arbiter #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .r0(r0_if), .r1(r1_if),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_regce(bram_regce), .bram_rst(bram_rst), .bram_dout(bram_dout)
  );

  bram_port_arbiter #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .READ_LATENCY(3), .CLEAR_ON_RESET(0)) dut_nofill (
    .clk(clk), .rst(rst), .init_done(init2), .r0(q0_if), .r1(q1_if),
    .bram_en(en2), .bram_we(we2), .bram_addr(addr2), .bram_din(din2),
    .bram_regce(regce2), .bram_rst(brst2), .bram_dout(dout2)
  );

  // Read-first BRAM: address sampled at one edge, data visible after the third edge
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] p1, p2, p3;
  always @(posedge clk) begin
    if (bram_en) begin
      p1 <= mem[bram_addr];
      if (bram_we) mem[bram_addr] <= bram_din;
    end
    p2 <= p1;
    p3 <= p2;
  end
  assign bram_dout = p3;

  typedef struct {
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } arb_vec_t;
  arb_vec_t tbl [10];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rsp_t;
  exp_rsp_t      exp_q [$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_data [2];
  logic          hold [2];
  logic          rv [2];
  logic          rw [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic          g0, g1, ev0, ev1;
  int            last_gnt, gp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      r0_if.valid = v; r0_if.we = we; r0_if.addr = a; r0_if.wdata = d;
    end else begin
      r1_if.valid = v; r1_if.we = we; r1_if.addr = a; r1_if.wdata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_rsp(input int p, input logic [DW-1:0] data);
    for (int k = 1; k <= 4; k++) begin
      cyc_start();
      if (k == 1) idle();
      sample();
      chk($sformatf("rsp%0d_valid_t%0d", p, k), 32'(p == 0 ? r0_if.rsp_valid : r1_if.rsp_valid), 32'(k == 4));
      chk($sformatf("rsp%0d_other_quiet", p), 32'(p == 0 ? r1_if.rsp_valid : r0_if.rsp_valid), 32'd0);
      if (k == 4) chk($sformatf("rsp%0d_data", p), 32'(p == 0 ? r0_if.rsp_data : r1_if.rsp_data), 32'(data));
    end
  endtask

  task automatic fill_check(input int n, input bit with_nofill);
    for (int i = 0; i < n; i++) begin
      sample();
      chk("fill_en", 32'(bram_en), 32'd1);
      chk("fill_we", 32'(bram_we), 32'd1);
      chk("fill_addr", 32'(bram_addr), 32'(i));
      chk("fill_din", 32'(bram_din), 32'd0);
      chk("fill_held_off", 32'(r0_if.ready), 32'd0);
      chk("fill_no_rsp", 32'(r0_if.rsp_valid | r1_if.rsp_valid), 32'd0);
      chk("fill_init_low", 32'(init_done), 32'd0);
      if (with_nofill && i == 0) begin
        chk("nofill_init_done", 32'(init2), 32'd1);
        chk("nofill_ready", 32'(q0_if.ready), 32'd1);
      end
      if (with_nofill && i == 1) begin
        chk("nofill_issue", {29'd0, en2, we2, 1'b0}, 32'h4);
        chk("nofill_addr", 32'(addr2), 32'd2);
        chk("nofill_din", 32'(din2), 32'd0);
      end
      cyc_start();
      if (with_nofill && i == 0) q0_if.valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1};

    idle();
    q0_if.valid = 1'b1; q0_if.we = 1'b0; q0_if.addr = 4'd2; q0_if.wdata = '0;
    q1_if.valid = 1'b0; q1_if.we = 1'b0; q1_if.addr = '0;   q1_if.wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_bram_rst", 32'(bram_rst), 32'd1);
    chk("rst_regce", 32'(bram_regce & regce2), 32'd1);
    chk("rst_nofill_bram_rst", 32'(brst2), 32'd1);
    chk("rst_en_we", {30'd0, bram_en, bram_we}, 32'd0);
    chk("rst_addr_din", {10'd0, bram_addr, bram_din}, 32'd0);
    chk("rst_init", 32'(init_done | init2), 32'd0);
    chk("rst_nofill_ready", 32'(q0_if.ready), 32'd0);
    chk("rst_rsp", {29'd0, r0_if.rsp_valid, r1_if.rsp_valid, q1_if.rsp_valid}, 32'd0);
    chk("rst_rsp_data", 32'(r0_if.rsp_data | r1_if.rsp_data | q1_if.rsp_data), 32'd0);

    // Fill after reset, with a read held off until init_done; no-fill instance accepts at once
    cyc_start();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd5, '0);
    fill_check(DEPTH, 1'b1);
    sample();
    chk("init_done_after_fill", 32'(init_done), 32'd1);
    chk("idle_bram_en", 32'(bram_en), 32'd0);
    chk("held_read_accepted", 32'(r0_if.ready), 32'd1);
    expect_rsp(0, '0);

    // Arbitration vectors
    for (int i = 0; i < 10; i++) begin
      cyc_start();
      drive(0, tbl[i].v0, 1'b0, '0, '0);
      drive(1, tbl[i].v1, 1'b0, '0, '0);
      sample();
      chk($sformatf("tbl%0d_ready0", i), 32'(r0_if.ready), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d_ready1", i), 32'(r1_if.ready), 32'(tbl[i].r1));
    end
    cyc_start();
    idle();
    repeat (6) cyc_start();

    // Write then read the same address
    drive(0, 1'b1, 1'b1, 4'd3, 18'h2A5);
    sample();
    chk("wr_accept", 32'(r0_if.ready), 32'd1);
    cyc_start();
    drive(0, 1'b1, 1'b0, 4'd3, '0);
    sample();
    chk("rd_accept", 32'(r0_if.ready), 32'd1);
    expect_rsp(0, 18'h2A5);

    // Both hold reads: grants alternate (r1 first, r0 won last), responses alternate 4 cycles later
    cyc_start();
    drive(0, 1'b1, 1'b0, 4'd3, '0);
    drive(1, 1'b1, 1'b0, 4'd5, '0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc_start();
      if (k == 6) idle();
      sample();
      if (k < 6) begin
        chk($sformatf("alt%0d_ready0", k), 32'(r0_if.ready), 32'(k % 2 == 1));
        chk($sformatf("alt%0d_ready1", k), 32'(r1_if.ready), 32'(k % 2 == 0));
      end
      chk($sformatf("alt%0d_rsp0", k), 32'(r0_if.rsp_valid), 32'(k >= 4 && (k - 4) % 2 == 1));
      chk($sformatf("alt%0d_rsp1", k), 32'(r1_if.rsp_valid), 32'(k >= 4 && (k - 4) % 2 == 0));
      if (k >= 4 && (k - 4) % 2 == 1) chk("alt_rsp0_data", 32'(r0_if.rsp_data), 32'h2A5);
      if (k >= 4 && (k - 4) % 2 == 0) chk("alt_rsp1_data", 32'(r1_if.rsp_data), 32'd0);
    end

    // r1 writes, r0 reads the same address the next cycle
    cyc_start();
    drive(1, 1'b1, 1'b1, 4'd7, 18'h111);
    sample();
    chk("x_wr_accept", 32'(r1_if.ready), 32'd1);
    cyc_start();
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b1, 1'b0, 4'd7, '0);
    sample();
    chk("x_rd_accept", 32'(r0_if.ready), 32'd1);
    expect_rsp(0, 18'h111);
    chk("x_r1_data_untouched", 32'(r1_if.rsp_data), 32'd0);
    cyc_start();
    sample();
    chk("x_r0_data_holds", {13'd0, r0_if.rsp_valid, r0_if.rsp_data}, 32'h111);

    // Reset with three reads in flight, then reset again mid-fill
    for (int k = 0; k < 3; k++) begin
      cyc_start();
      drive(0, 1'b1, 1'b0, 4'd3, '0);
      sample();
      chk("inflight_accept", 32'(r0_if.ready), 32'd1);
    end
    cyc_start();
    idle();
    rst = 1'b1;
    sample();
    chk("midop_rst_en", 32'(bram_en), 32'd0);
    chk("midop_rst_init", 32'(init_done), 32'd0);
    cyc_start();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd3, '0);
    fill_check(6, 1'b0);
    rst = 1'b1;
    sample();
    chk("midclear_rst_ready", 32'(r0_if.ready), 32'd0);
    cyc_start();
    rst = 1'b0;
    fill_check(DEPTH, 1'b0);
    sample();
    chk("refill_init_done", 32'(init_done), 32'd1);
    chk("refill_accept", 32'(r0_if.ready), 32'd1);
    expect_rsp(0, '0);

    // Random traffic against a transaction-level model
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_data[0] = '0;
    last_data[1] = '0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    last_gnt = 0;
    for (int n = 0; n < NRAND + 8; n++) begin
      cyc_start();
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          rv[p] = (n < NRAND) && ($urandom_range(0, 3) != 0);
          rw[p] = 1'($urandom_range(0, 1));
          ra[p] = AW'($urandom_range(0, DEPTH - 1));
          rd[p] = DW'($urandom);
        end
        drive(p, rv[p], rw[p], ra[p], rd[p]);
      end
      sample();
      g0 = rv[0] && (!rv[1] || last_gnt == 1);
      g1 = rv[1] && (!rv[0] || last_gnt == 0);
      chk("rand_ready0", 32'(r0_if.ready), 32'(g0));
      chk("rand_ready1", 32'(r1_if.ready), 32'(g1));
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == n) begin
        if (exp_q[0].id == 0) ev0 = 1'b1;
        else                  ev1 = 1'b1;
        last_data[exp_q[0].id] = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      chk("rand_rsp0_valid", 32'(r0_if.rsp_valid), 32'(ev0));
      chk("rand_rsp1_valid", 32'(r1_if.rsp_valid), 32'(ev1));
      chk("rand_rsp0_data", 32'(r0_if.rsp_data), 32'(last_data[0]));
      chk("rand_rsp1_data", 32'(r1_if.rsp_data), 32'(last_data[1]));
      if (g0 || g1) begin
        gp = g1 ? 1 : 0;
        last_gnt = gp;
        if (rw[gp]) ref_mem[ra[gp]] = rd[gp];
        else exp_q.push_back('{due: n + 4, id: gp, data: ref_mem[ra[gp]]});
      end
      hold[0] = rv[0] && !g0;
      hold[1] = rv[1] && !g1;
    end
    chk("rand_all_responses_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
